rca_serial_adder: RTL and testbench

Multi-cycle wide adder built around one N-bit ripple-carry adder (RCA #(N)) slice. It accepts W-bit operands over a valid/ready handshake and feeds the RCA one N-bit chunk per cycle, LSB chunk first, with the carry registered between chunks. It collects the chunk sums into a W-bit result and presents it downstream over a second valid/ready handshake. It extends the 4-bit RCA datapath to wide operands without a W-bit ripple chain.

---
 rtl/rca_serial_adder.sv | 163 ++++++++++++++++
 tb/tb_rca_serial_adder.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/rca_serial_adder.sv
// rtl/rca_serial_adder.sv - multi-cycle wide adder built on one N-bit ripple-carry slice
//
// rca_serial_adder:
//   Takes W-bit operands over a valid/ready handshake. It adds them one N-bit chunk
//   per cycle, LSB chunk first, through a single N-bit ripple-carry adder. The carry
//   is registered between chunks. The {cout, sum} result is presented over a second
//   valid/ready handshake.
//
//   Ports:
//     clk        rising-edge clock
//     rst_n      asynchronous active-low reset
//     in_valid   operand request valid
//     in_ready   block can accept operands (state == IDLE)
//     a, b       W-bit operands
//     cin        carry into chunk 0
//     out_valid  result valid (state == DONE)
//     out_ready  downstream accepts result
//     sum        registered W-bit result, held until the next completion
//     cout       registered carry out of the top chunk
//     busy       high in ADD or DONE
//
// rca:
//   Plain N-bit ripple-carry adder (a + b + cin -> {cout, sum}).

module rca #(
   parameter int N = 4
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         cin,
   output logic [N-1:0] sum,
   output logic         cout
);

   logic [N:0] c;

   assign c[0] = cin;

   for (genvar i = 0; i < N; i++) begin : g_fa
      assign sum[i]   = a[i] ^ b[i] ^ c[i];
      assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
   end

   assign cout = c[N];

endmodule

module rca_serial_adder #(
   parameter int N = 4,
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         cin,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] sum,
   output logic         cout,
   output logic         busy
);

   localparam int CHUNKS = W / N;
   localparam int CNT_W  = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
   localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(CHUNKS - 1);

   if ((W % N) != 0 || W < N) begin : g_bad_params
      $fatal(1, "rca_serial_adder: W must be a positive multiple of N");
   end

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   logic [W-1:0]     op_a;
   logic [W-1:0]     op_b;
   logic             carry;
   logic [W-1:0]     result;
   logic [CNT_W-1:0] cnt;

   logic [N-1:0]     rca_sum;
   logic             rca_cout;
   logic [W-1:0]     result_next;

   rca #(.N(N)) u_rca (
      .a    (op_a[N-1:0]),
      .b    (op_b[N-1:0]),
      .cin  (carry),
      .sum  (rca_sum),
      .cout (rca_cout)
   );

   // Chunk sums enter at the top and shift down, so after CHUNKS cycles the first
   // (LSB) chunk has reached bits [N-1:0].
   if (CHUNKS == 1) begin : g_single
      assign result_next = rca_sum;
   end else begin : g_multi
      assign result_next = {rca_sum, result[W-1:N]};
   end

   assign in_ready = (state == IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         op_a      <= '0;
         op_b      <= '0;
         carry     <= 1'b0;
         result    <= '0;
         cnt       <= '0;
         sum       <= '0;
         cout      <= 1'b0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  op_a  <= a;
                  op_b  <= b;
                  carry <= cin;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= ADD;
               end
            end
            ADD: begin
               carry  <= rca_cout;
               result <= result_next;
               op_a   <= op_a >> N;
               op_b   <= op_b >> N;
               cnt    <= cnt + CNT_W'(1);
               if (cnt == LAST_CHUNK) begin
                  // Publish the result including this cycle's top chunk.
                  sum       <= result_next;
                  cout      <= rca_cout;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: begin
               out_valid <= 1'b0;
               busy      <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rca_serial_adder.sv
// tb/tb_rca_serial_adder.sv - scoreboard bench for rca_serial_adder

module tb_rca_serial_adder;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] a = '0;
   logic [15:0] b = '0;
   logic        cin = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [15:0] sum;
   logic        cout;
   logic        busy;

   // single-chunk instance (W == N)
   logic        s_in_valid = 1'b0;
   logic        s_in_ready;
   logic [3:0]  s_a = '0;
   logic [3:0]  s_b = '0;
   logic        s_cin = 1'b0;
   logic        s_out_valid;
   logic [3:0]  s_sum;
   logic        s_cout;
   logic        s_busy;

   int checks = 0;
   int errors = 0;
   int ov_cycles = 0;
   logic [16:0] exp_q[$];

   always #5 clk = ~clk;

   rca_serial_adder #(.N(4), .W(16)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .cout(cout), .busy(busy)
   );

   rca_serial_adder #(.N(4), .W(4)) dut_single (
      .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
      .a(s_a), .b(s_b), .cin(s_cin), .out_valid(s_out_valid), .out_ready(1'b1),
      .sum(s_sum), .cout(s_cout), .busy(s_busy)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: compares every presented result against the scoreboard head.
   always @(negedge clk) begin
      if (rst_n && out_valid) begin
         ov_cycles++;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result: got 0x%0h with empty scoreboard", {cout, sum});
         end else if (out_ready) begin
            check("result", {15'd0, cout, sum}, {15'd0, exp_q.pop_front()});
         end else begin
            check("held_result", {15'd0, cout, sum}, {15'd0, exp_q[0]});
         end
      end
   end

   // Issue one operand set; returns after the accepting edge (+1).
   task automatic send(input logic [15:0] ta, input logic [15:0] tb, input logic tc);
      int n = 0;
      while (!in_ready && n < 50) begin
         @(posedge clk); #1; n++;
      end
      if (!in_ready) check("in_ready_timeout", 32'd0, 32'd1);
      a = ta; b = tb; cin = tc; in_valid = 1'b1;
      exp_q.push_back({1'b0, ta} + {1'b0, tb} + {16'd0, tc});
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   // Count edges after the accept until out_valid, checking busy along the way.
   task automatic wait_result(output int edges);
      edges = 0;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk); #1;
         if (out_valid) begin
            edges = i;
            break;
         end
         check("busy_in_add", {31'd0, busy}, 32'd1);
      end
      if (edges == 0) check("out_valid_timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(posedge clk); #1; n++;
      end
      check("scoreboard_drained", exp_q.size(), 32'd0);
   endtask

   initial begin
      int edges;
      time t_prev;
      time t_acc;
      int ov_start;

      // reset state
      #2;
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_sum", {16'd0, sum}, 32'd0);
      check("rst_cout", {31'd0, cout}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // 1: basic add, latency and busy
      send(16'h0001, 16'h0001, 1'b0);
      check("busy_after_accept", {31'd0, busy}, 32'd1);
      wait_result(edges);
      check("latency", edges, 32'd4);
      check("busy_in_done", {31'd0, busy}, 32'd1);
      wait_drain();

      // 2, 3: full carry propagation
      send(16'hFFFF, 16'h0001, 1'b0);
      wait_drain();
      send(16'hFFFF, 16'hFFFF, 1'b1);
      wait_drain();

      // 4: operand changes during ADD ignored, DONE held with out_ready low
      out_ready = 1'b0;
      send(16'hA5A5, 16'h5A5A, 1'b0);
      a = 16'h1111; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      wait_result(edges);
      for (int i = 0; i < 5; i++) begin
         check("in_ready_in_done", {31'd0, in_ready}, 32'd0);
         check("sum_stable", {16'd0, sum}, 32'h0000FFFF);
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("in_ready_after_handshake", {31'd0, in_ready}, 32'd1);
      check("out_valid_after_handshake", {31'd0, out_valid}, 32'd0);
      check("sum_held_in_idle", {16'd0, sum}, 32'h0000FFFF);
      wait_drain();

      // 5: asynchronous abort mid-ADD
      send(16'h00FF, 16'h0001, 1'b0);
      @(posedge clk); @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      check("abort_out_valid", {31'd0, out_valid}, 32'd0);
      check("abort_sum", {16'd0, sum}, 32'd0);
      check("abort_cout", {31'd0, cout}, 32'd0);
      check("abort_in_ready", {31'd0, in_ready}, 32'd1);
      check("abort_busy", {31'd0, busy}, 32'd0);
      exp_q.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      send(16'h1234, 16'h4321, 1'b0);
      wait_drain();

      // 6: back-to-back with in_valid and out_ready held high
      ov_start = ov_cycles;
      a = 16'h8000; b = 16'h8000; cin = 1'b0;
      in_valid = 1'b1;
      t_prev = 0;
      for (int k = 0; k < 3; k++) begin
         int n = 0;
         while (!in_ready && n < 50) begin
            @(posedge clk); #1; n++;
         end
         exp_q.push_back(17'h10000);
         @(posedge clk);
         t_acc = $time;
         #1;
         if (k == 2) in_valid = 1'b0;
         if (k > 0) check("initiation_interval", 32'(t_acc - t_prev), 32'd60);
         t_prev = t_acc;
      end
      wait_drain();
      @(posedge clk); #1;
      check("out_valid_cycles", ov_cycles - ov_start, 32'd3);

      // W == N: single ADD cycle
      s_a = 4'hF; s_b = 4'h1; s_cin = 1'b1; s_in_valid = 1'b1;
      @(posedge clk); #1;
      s_in_valid = 1'b0;
      check("single_busy", {31'd0, s_busy}, 32'd1);
      @(posedge clk); #1;
      check("single_out_valid", {31'd0, s_out_valid}, 32'd1);
      check("single_result", {27'd0, s_cout, s_sum}, 32'h11);
      @(posedge clk); #1;
      check("single_in_ready", {31'd0, s_in_ready}, 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
